// File: rtl/bgread_pkg.sv
// Shared types and constants for the background reader: FSM states,
// RGB565 field positions, default raster size and the 565->10-bit expansion.
package bgread_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  // MSB replication so full-scale maps to full-scale and zero stays zero.
  function automatic logic [29:0] expand565(input logic [15:0] w);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = w[R_MSB:R_LSB];
    g = w[G_MSB:G_LSB];
    b = w[B_MSB:B_LSB];
    return {r, r, g, g[5:2], b, b};
  endfunction

endpackage

// File: rtl/bgread_fifo.sv
// Synchronous FIFO, first-word-fall-through head; push ignored when full, pop ignored when empty.
// Simultaneous push and pop leave the occupancy unchanged.
module bgread_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (o_count == '0);
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/background_reader.sv
// Streams one frame of RGB565 words from SRAM as 10-bit RGB pixels with raster x/y; reads are
// credit-limited by FIFO space so i_ready backpressure never overflows it. BGREAD_GRAY_EN: grayscale output.
module background_reader
  import bgread_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter logic [19:0] BASE_ADDR  = 20'h0,
  parameter int          RD_LAT     = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_sram_rd,
  output logic [19:0] o_sram_addr,
  input  logic [15:0] i_sram_dq,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [9:0]  o_r,
  output logic [9:0]  o_g,
  output logic [9:0]  o_b,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_frame_done
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int NW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NW-1:0]     r_rd_cnt;
  logic [19:0]       r_addr;
  logic [RD_LAT-1:0] r_vld_sr;
  logic [RD_LAT-1:0] w_vld_sr_nxt;
  logic [CW-1:0]     w_infl;
  logic [CW-1:0]     w_fifo_cnt;
  logic [CW:0]       w_pending;
  logic              w_rd;
  logic              w_last_rd;
  logic              w_push;
  logic              w_hs;
  logic              w_last_px;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [15:0]       w_head;
  logic [29:0]       w_exp;
  logic [10:0]       r_x;
  logic [10:0]       r_y;
  logic              r_done;

  // Every outstanding read already owns a FIFO slot, so occupancy + in-flight bounds the fill level.
  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_infl = w_infl + CW'(r_vld_sr[i]);
    end
    w_vld_sr_nxt    = r_vld_sr << 1;
    w_vld_sr_nxt[0] = w_rd;
  end

  assign w_pending = {1'b0, w_fifo_cnt} + {1'b0, w_infl};
  assign w_rd      = (r_state == FETCH) && !w_fifo_full && (w_pending < (CW+1)'(FIFO_DEPTH));
  assign w_last_rd = w_rd && (r_rd_cnt == NW'(TOTAL - 1));
  assign w_push    = r_vld_sr[RD_LAT-1];
  assign w_hs      = o_valid && i_ready;
  assign w_last_px = (r_x == 11'(H_ACTIVE - 1)) && (r_y == 11'(V_ACTIVE - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = FETCH;
      FETCH:   if (w_last_rd) w_state_nxt = DRAIN;
      DRAIN:   if (w_hs && w_last_px) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_cnt <= '0;
      r_addr   <= '0;
      r_vld_sr <= '0;
    end else begin
      r_vld_sr <= w_vld_sr_nxt;
      if (r_state == IDLE && i_start) begin
        r_rd_cnt <= '0;
        r_addr   <= BASE_ADDR;
      end else if (w_rd) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        r_addr   <= r_addr + 20'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_hs && w_last_px;
      if (w_hs) begin
        if (r_x == 11'(H_ACTIVE - 1)) begin
          r_x <= '0;
          r_y <= (r_y == 11'(V_ACTIVE - 1)) ? 11'd0 : r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  bgread_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (i_sram_dq),
    .i_pop   (w_hs),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign w_exp = expand565(w_head);

`ifdef BGREAD_GRAY_EN
  logic [11:0] w_sum;
  logic [9:0]  w_gray;
  assign w_sum  = 12'(w_exp[29:20]) + {1'b0, w_exp[19:10], 1'b0} + 12'(w_exp[9:0]);
  assign w_gray = w_sum[11:2];
  assign o_r    = o_valid ? w_gray : '0;
  assign o_g    = o_valid ? w_gray : '0;
  assign o_b    = o_valid ? w_gray : '0;
`else
  assign o_r    = o_valid ? w_exp[29:20] : '0;
  assign o_g    = o_valid ? w_exp[19:10] : '0;
  assign o_b    = o_valid ? w_exp[9:0]   : '0;
`endif

  assign o_valid      = !w_fifo_empty;
  assign o_busy       = (r_state != IDLE);
  assign o_sram_rd    = w_rd;
  assign o_sram_addr  = r_addr;
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_frame_done = r_done;

endmodule

// File: tb/tb_background_reader.sv
// Bench for background_reader on a small 6x3 raster whose base address wraps past 20'hFFFFF,
// with a latency-accurate SRAM responder and a pixel model derived from address and raster rules.
module tb_background_reader;

  localparam int          H      = 6;
  localparam int          V      = 3;
  localparam int          TOTAL  = H * V;
  localparam int          RD_LAT = 2;
  localparam int          DEPTH  = 4;
  localparam logic [19:0] BASE   = 20'hFFFF9;
  localparam int          BUDGET = 2000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        o_busy;
  logic        o_sram_rd;
  logic [19:0] o_sram_addr;
  logic [15:0] i_sram_dq;
  logic        o_valid;
  logic        i_ready;
  logic [9:0]  o_r, o_g, o_b;
  logic [10:0] o_x, o_y;
  logic        o_frame_done;

  int errors = 0;
  int checks = 0;

  int          mode;
  logic [15:0] const_w;
  logic [15:0] seed;
  int          sram_cyc;
  int          due_q[$];
  logic [15:0] dat_q[$];
  logic [19:0] addr_q[$];

  background_reader #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BASE_ADDR  (BASE),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_sram_rd    (o_sram_rd),
    .o_sram_addr  (o_sram_addr),
    .i_sram_dq    (i_sram_dq),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] word_of(input logic [19:0] a);
    logic [15:0] t;
    case (mode)
      0:       return a[15:0];
      1:       return const_w;
      default: begin
        t = a[15:0] * 16'h9E37;
        return t ^ seed;
      end
    endcase
  endfunction

  function automatic logic [29:0] exp_rgb(input logic [15:0] w);
    int r, g, b, rr, gg, bb;
    r  = int'(w[15:11]);
    g  = int'(w[10:5]);
    b  = int'(w[4:0]);
    rr = r * 33;
    gg = g * 16 + g / 4;
    bb = b * 33;
`ifdef BGREAD_GRAY_EN
    rr = (rr + 2 * gg + bb) / 4;
    gg = rr;
    bb = rr;
`endif
    return {10'(rr), 10'(gg), 10'(bb)};
  endfunction

  // SRAM: data for a read seen in cycle c is presented during cycle c+RD_LAT, junk otherwise.
  initial begin
    sram_cyc  = 0;
    i_sram_dq = '0;
    forever begin
      @(negedge i_clk);
      if (o_sram_rd === 1'b1) begin
        due_q.push_back(sram_cyc + RD_LAT);
        dat_q.push_back(word_of(o_sram_addr));
        addr_q.push_back(o_sram_addr);
      end
      if (due_q.size() > 0 && due_q[0] == sram_cyc) begin
        i_sram_dq = dat_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        i_sram_dq = 16'($urandom);
      end
      sram_cyc++;
    end
  end

  function automatic logic [75:0] all_outs();
    return {o_busy, o_sram_rd, o_sram_addr, o_valid, o_r, o_g, o_b, o_x, o_y, o_frame_done};
  endfunction

  task automatic flush_sram();
    due_q.delete();
    dat_q.delete();
  endtask

  task automatic run_frame(input int rdy_pct, input int restart_at, input bit rel_rst);
    int npix, ndone, cyc, last_hs, max_cnt, extra;
    bit stalled;
    logic [51:0] held;
    logic [29:0] ec;
    addr_q.delete();
    @(negedge i_clk);
    if (rel_rst) i_rst = 1'b0;
    i_start = 1'b1;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_accept busy=%b expected=1", o_busy);
    end
    npix = 0; ndone = 0; cyc = 0; last_hs = -10; max_cnt = 0; stalled = 0; held = '0;
    while (ndone == 0 && cyc < BUDGET) begin
      if (stalled) begin
        checks++;
        if ({o_valid, o_r, o_g, o_b, o_x, o_y} !== {1'b1, held}) begin
          errors++;
          $display("FAIL stall_hold got=%h expected=%h", {o_valid, o_r, o_g, o_b, o_x, o_y}, {1'b1, held});
        end
      end
      if (o_frame_done === 1'b1) begin
        ndone++;
        checks++;
        if (last_hs != cyc - 1 || o_busy !== 1'b0 || o_x !== 11'd0 || o_y !== 11'd0) begin
          errors++;
          $display("FAIL frame_done_timing last_hs=%0d cyc=%0d busy=%b x=%0d y=%0d expected busy=0 x=0 y=0 one cycle after last pixel",
                   last_hs, cyc, o_busy, o_x, o_y);
        end
      end
      if (int'(dut.u_fifo.o_count) > max_cnt) max_cnt = int'(dut.u_fifo.o_count);
      i_start = (cyc == restart_at);
      i_ready = ($urandom_range(99, 0) < 32'(rdy_pct));
      stalled = o_valid && !i_ready;
      held    = {o_r, o_g, o_b, o_x, o_y};
      if (o_valid === 1'b1 && i_ready) begin
        checks++;
        if (npix >= TOTAL) begin
          errors++;
          $display("FAIL extra_pixel index=%0d expected at most %0d pixels", npix, TOTAL);
        end else begin
          ec = exp_rgb(word_of(BASE + 20'(npix)));
          if ({o_r, o_g, o_b, o_x, o_y} !== {ec, 11'(npix % H), 11'(npix / H)}) begin
            errors++;
            $display("FAIL pixel_%0d got rgb=%h/%h/%h xy=%0d,%0d expected rgb=%h/%h/%h xy=%0d,%0d",
                     npix, o_r, o_g, o_b, o_x, o_y, ec[29:20], ec[19:10], ec[9:0], npix % H, npix / H);
          end
        end
        if (npix == TOTAL - 1) last_hs = cyc;
        npix++;
      end
      @(negedge i_clk);
      i_start = 1'b0;
      cyc++;
    end
    checks++;
    if (ndone == 0) begin
      errors++;
      $display("FAIL frame_timeout pixels=%0d expected %0d within %0d cycles", npix, TOTAL, BUDGET);
      i_rst = 1'b1;
      @(negedge i_clk);
      flush_sram();
      i_rst = 1'b0;
    end
    checks++;
    if (npix != TOTAL) begin
      errors++;
      $display("FAIL pixel_count got=%0d expected=%0d", npix, TOTAL);
    end
    checks++;
    if (max_cnt > DEPTH) begin
      errors++;
      $display("FAIL fifo_bound got=%0d expected<=%0d", max_cnt, DEPTH);
    end
    extra = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_busy !== 1'b0 || o_frame_done !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL idle_after_frame busy_or_done_cycles=%0d expected=0", extra);
    end
    checks++;
    if (addr_q.size() != TOTAL) begin
      errors++;
      $display("FAIL read_count got=%0d expected=%0d", addr_q.size(), TOTAL);
    end
    for (int k = 0; k < addr_q.size() && k < TOTAL; k++) begin
      checks++;
      if (addr_q[k] !== BASE + 20'(k)) begin
        errors++;
        $display("FAIL read_addr_%0d got=%h expected=%h", k, addr_q[k], BASE + 20'(k));
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #2;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_async outputs=%h expected=0", all_outs());
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_held outputs=%h expected=0", all_outs());
    end
    mode = 0;
    run_frame(100, -1, 1'b1);
  endtask

  task automatic test_colors();
    logic [15:0] words [3];
    words[0] = 16'hFFFF;
    words[1] = 16'hF800;
    words[2] = 16'h07E0;
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      const_w = words[i];
      run_frame(100, -1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    mode = 2;
    for (int i = 0; i < 2; i++) begin
      seed = 16'($urandom);
      run_frame(25, -1, 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    mode = 2;
    seed = 16'($urandom);
    run_frame(60, 4, 1'b0);
  endtask

  task automatic test_reset_midframe();
    mode = 2;
    seed = 16'($urandom);
    @(negedge i_clk);
    i_start = 1'b1;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL midframe_prereset busy=%b valid=%b expected busy=1 valid=1", o_busy, o_valid);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midframe_reset_async outputs=%h expected=0", all_outs());
    end
    @(negedge i_clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midframe_reset_held outputs=%h expected=0", all_outs());
    end
    flush_sram();
    run_frame(50, -1, 1'b1);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b0;
    mode    = 0;
    const_w = '0;
    seed    = '0;
    test_reset();
    test_colors();
    test_backpressure();
    test_start_ignored();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
